// File: rtl/trap_pkg.sv
// trap_pkg: CSR addresses, mstatus/mie bit positions, cause codes and sequencer states
package trap_pkg;
  localparam int CSR_AW = 12;
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MEIE       = 11;
  localparam int CAUSE_M_EXT_IRQ = 11;
  typedef enum logic [3:0] {
    IDLE, RD_STATUS, RD_MIE, WR_STATUS, WR_EPC, WR_CAUSE, WR_TVAL, RD_TVEC,
    MR_RD_STATUS, MR_WR_STATUS, MR_RD_EPC, REDIRECT
  } state_t;
endpackage

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: trap requests, CSR port and fetch redirect; master is the sequencer side
interface trap_sequencer_if #(parameter int XLEN = 32);
  import trap_pkg::*;
  logic              exc_valid;
  logic [4:0]        exc_cause;
  logic [XLEN-1:0]   exc_pc;
  logic [XLEN-1:0]   exc_tval;
  logic              mret_valid;
  logic              irq_ext;
  logic [XLEN-1:0]   irq_pc;
  logic              csr_own;
  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic              csr_we;
  logic              csr_re;
  logic [XLEN-1:0]   csr_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  modport master(
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, irq_ext, irq_pc, csr_rdata,
    output csr_own, csr_addr, csr_wdata, csr_we, csr_re, redirect_valid, redirect_pc
  );
  modport slave(
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, irq_ext, irq_pc, csr_rdata,
    input  csr_own, csr_addr, csr_wdata, csr_we, csr_re, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_target_calc.sv
// trap_target_calc: mtvec + trap kind -> trap entry PC
// TRAP_VECTORED_EN enables vectored mode (mtvec[1:0]==01) for interrupts.
module trap_target_calc #(
  parameter int XLEN = 32,
  parameter int IRQ_CAUSE = 11
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic            irq,
  output logic [XLEN-1:0] target
);
  logic [XLEN-1:0] base;
  assign base = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign target = (irq && mtvec[1:0] == 2'b01) ? base + XLEN'(4 * IRQ_CAUSE) : base;
`else
  logic unused_mode;
  assign unused_mode = ^{irq, mtvec[1:0]};
  assign target = base;
`endif
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap/MRET sequencer driving the CSR port and fetch redirect
// Optional: TRAP_VECTORED_EN (vectored interrupt targets, see trap_target_calc).
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IRQ_CAUSE = CAUSE_M_EXT_IRQ
) (
  input logic clk,
  input logic rst,
  trap_sequencer_if.master b
);
  state_t state;
  logic [XLEN-1:0] cause, epc, tval, mst, target;

  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
    trap_status = s;
    trap_status[MSTATUS_MPIE] = s[MSTATUS_MIE];
    trap_status[MSTATUS_MIE] = 1'b0;
    trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  endfunction

  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
    mret_status = s;
    mret_status[MSTATUS_MIE] = s[MSTATUS_MPIE];
    mret_status[MSTATUS_MPIE] = 1'b1;
    mret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  endfunction

  trap_target_calc #(.XLEN(XLEN), .IRQ_CAUSE(IRQ_CAUSE)) u_target (
    .mtvec(b.csr_rdata), .irq(cause[XLEN-1]), .target(target)
  );

  // Outputs are registered for the state being entered, so read data is consumed at the edge leaving a read state.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      b.csr_own <= 1'b0;
      b.csr_we <= 1'b0;
      b.csr_re <= 1'b0;
      b.redirect_valid <= 1'b0;
      b.csr_addr <= '0;
      b.csr_wdata <= '0;
      b.redirect_pc <= '0;
      cause <= '0;
      epc <= '0;
      tval <= '0;
      mst <= '0;
    end else begin
      b.csr_we <= 1'b0;
      b.csr_re <= 1'b0;
      b.redirect_valid <= 1'b0;
      case (state)
        IDLE:
          if (b.exc_valid || b.irq_ext) begin
            state <= RD_STATUS;
            b.csr_own <= 1'b1;
            b.csr_re <= 1'b1;
            b.csr_addr <= CSR_MSTATUS;
            cause <= b.exc_valid ? {1'b0, (XLEN-1)'(b.exc_cause)} : {1'b1, (XLEN-1)'(IRQ_CAUSE)};
            epc <= b.exc_valid ? {b.exc_pc[XLEN-1:2], 2'b00} : {b.irq_pc[XLEN-1:2], 2'b00};
            tval <= b.exc_valid ? b.exc_tval : '0;
            if (!b.exc_valid && b.mret_valid) begin
              state <= MR_RD_STATUS;
              cause <= cause;
              epc <= epc;
              tval <= tval;
            end
          end else if (b.mret_valid) begin
            state <= MR_RD_STATUS;
            b.csr_own <= 1'b1;
            b.csr_re <= 1'b1;
            b.csr_addr <= CSR_MSTATUS;
          end
        RD_STATUS: begin
          mst <= b.csr_rdata;
          state <= cause[XLEN-1] ? RD_MIE : WR_STATUS;
          b.csr_re <= cause[XLEN-1];
          b.csr_we <= !cause[XLEN-1];
          b.csr_addr <= cause[XLEN-1] ? CSR_MIE : CSR_MSTATUS;
          b.csr_wdata <= cause[XLEN-1] ? '0 : trap_status(b.csr_rdata);
        end
        RD_MIE:
          if (mst[MSTATUS_MIE] && b.csr_rdata[MIE_MEIE]) begin
            state <= WR_STATUS;
            b.csr_we <= 1'b1;
            b.csr_addr <= CSR_MSTATUS;
            b.csr_wdata <= trap_status(mst);
          end else begin
            state <= IDLE;
            b.csr_own <= 1'b0;
            b.csr_addr <= '0;
          end
        WR_STATUS: begin
          state <= WR_EPC;
          b.csr_we <= 1'b1;
          b.csr_addr <= CSR_MEPC;
          b.csr_wdata <= epc;
        end
        WR_EPC: begin
          state <= WR_CAUSE;
          b.csr_we <= 1'b1;
          b.csr_addr <= CSR_MCAUSE;
          b.csr_wdata <= cause;
        end
        WR_CAUSE: begin
          state <= WR_TVAL;
          b.csr_we <= 1'b1;
          b.csr_addr <= CSR_MTVAL;
          b.csr_wdata <= tval;
        end
        WR_TVAL: begin
          state <= RD_TVEC;
          b.csr_re <= 1'b1;
          b.csr_addr <= CSR_MTVEC;
          b.csr_wdata <= '0;
        end
        RD_TVEC: begin
          state <= REDIRECT;
          b.redirect_valid <= 1'b1;
          b.redirect_pc <= target;
          b.csr_addr <= '0;
        end
        MR_RD_STATUS: begin
          state <= MR_WR_STATUS;
          b.csr_we <= 1'b1;
          b.csr_wdata <= mret_status(b.csr_rdata);
        end
        MR_WR_STATUS: begin
          state <= MR_RD_EPC;
          b.csr_re <= 1'b1;
          b.csr_addr <= CSR_MEPC;
          b.csr_wdata <= '0;
        end
        MR_RD_EPC: begin
          state <= REDIRECT;
          b.redirect_valid <= 1'b1;
          b.redirect_pc <= {b.csr_rdata[XLEN-1:2], 2'b00};
          b.csr_addr <= '0;
        end
        REDIRECT: begin
          state <= IDLE;
          b.csr_own <= 1'b0;
          b.redirect_pc <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: CSR file model plus scoreboard of expected CSR writes and redirects
module tb_trap_sequencer;
  import trap_pkg::*;
  typedef struct packed {
    logic        redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          k;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, acc = 0, tests = 0, fails = 0;
  ev_t exp_q[$];
  logic [31:0] m_status = 0, m_ie = 0, m_tvec = 0, m_epc = 0, m_cause = 0, m_tval = 0;

  trap_sequencer_if #(.XLEN(32)) bus();
  trap_sequencer #(.XLEN(32), .IRQ_CAUSE(11)) dut (.clk(clk), .rst(rst), .b(bus.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb
    case (bus.csr_addr)
      CSR_MSTATUS: bus.csr_rdata = m_status;
      CSR_MIE:     bus.csr_rdata = m_ie;
      CSR_MTVEC:   bus.csr_rdata = m_tvec;
      CSR_MEPC:    bus.csr_rdata = m_epc;
      CSR_MCAUSE:  bus.csr_rdata = m_cause;
      CSR_MTVAL:   bus.csr_rdata = m_tval;
      default:     bus.csr_rdata = 32'h0;
    endcase

  // Scoreboard: every write or redirect must match the next expected event, including its cycle offset from accept.
  always @(negedge clk) begin
    ev_t e, got;
    if (!rst && (bus.csr_we || bus.redirect_valid)) begin
      tests++;
      got = '{bus.redirect_valid, bus.redirect_valid ? 12'h0 : bus.csr_addr,
              bus.redirect_valid ? bus.redirect_pc : bus.csr_wdata, cyc - acc};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected got redir=%0b addr=%h data=%h k=%0d required none", got.redir, got.addr, got.data, got.k);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL sb_event got redir=%0b addr=%h data=%h k=%0d required redir=%0b addr=%h data=%h k=%0d",
                   got.redir, got.addr, got.data, got.k, e.redir, e.addr, e.data, e.k);
        end
      end
    end
    if (!rst && bus.csr_we)
      case (bus.csr_addr)
        CSR_MSTATUS: m_status = bus.csr_wdata;
        CSR_MEPC:    m_epc = bus.csr_wdata;
        CSR_MCAUSE:  m_cause = bus.csr_wdata;
        CSR_MTVAL:   m_tval = bus.csr_wdata;
        default: ;
      endcase
  end

  task automatic idle_inputs;
    bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_pc = 0; bus.exc_tval = 0;
    bus.mret_valid = 0; bus.irq_ext = 0; bus.irq_pc = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.csr_own, bus.csr_we, bus.csr_re, bus.redirect_valid, bus.csr_addr, bus.csr_wdata, bus.redirect_pc} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got own=%0b we=%0b re=%0b rv=%0b addr=%h wdata=%h rpc=%h required all 0",
               bus.csr_own, bus.csr_we, bus.csr_re, bus.redirect_valid, bus.csr_addr, bus.csr_wdata, bus.redirect_pc);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.csr_own !== 1'b0) begin fails++; $display("FAIL idle_no_request got own=%0b required 0", bus.csr_own); end
  endtask

  task automatic test_exception(input logic [31:0] tvec, input logic mid_pulse);
    int own = 0;
    @(negedge clk);
    m_status = 32'h8; m_tvec = tvec; m_epc = 0; m_cause = 0; m_tval = 0;
    acc = cyc;
    exp_q.push_back('{1'b0, CSR_MSTATUS, 32'h1880, 2});
    exp_q.push_back('{1'b0, CSR_MEPC, 32'h1004, 3});
    exp_q.push_back('{1'b0, CSR_MCAUSE, 32'h2, 4});
    exp_q.push_back('{1'b0, CSR_MTVAL, 32'hDEAD, 5});
    exp_q.push_back('{1'b1, 12'h0, 32'h100, 7});
    bus.exc_valid = 1; bus.exc_cause = 2; bus.exc_pc = 32'h1006; bus.exc_tval = 32'hDEAD;
    bus.mret_valid = mid_pulse; bus.irq_ext = mid_pulse; bus.irq_pc = 32'h5550;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 20 && bus.csr_own; i++) begin
      bus.exc_valid = mid_pulse && i == 2; bus.mret_valid = mid_pulse && i == 2;
      bus.exc_cause = 7; bus.exc_pc = 32'h9000;
      own++;
      @(negedge clk);
    end
    idle_inputs();
    tests++;
    if (own !== 7) begin fails++; $display("FAIL exc_own_cycles got %0d required 7", own); end
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL exc_missing_events got %0d pending required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if ({m_epc, m_cause, m_tval, m_status} !== {32'h1004, 32'h2, 32'hDEAD, 32'h1880}) begin
      fails++;
      $display("FAIL exc_csr_state got epc=%h cause=%h tval=%h status=%h required 1004 2 dead 1880", m_epc, m_cause, m_tval, m_status);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (bus.csr_own !== 1'b0) begin fails++; $display("FAIL exc_no_retrigger got own=%0b required 0", bus.csr_own); end
  endtask

  task automatic test_irq(input logic [31:0] status, input logic [31:0] ie, input logic [31:0] tvec,
                          input logic [31:0] target, input int exp_own);
    int own = 0;
    logic en = status[3] && ie[11];
    @(negedge clk);
    m_status = status; m_ie = ie; m_tvec = tvec; m_epc = 32'h77; m_cause = 32'h77; m_tval = 32'h77;
    acc = cyc;
    if (en) begin
      exp_q.push_back('{1'b0, CSR_MSTATUS, (status & ~32'h8) | 32'h1880, 3});
      exp_q.push_back('{1'b0, CSR_MEPC, 32'h2000, 4});
      exp_q.push_back('{1'b0, CSR_MCAUSE, 32'h8000000B, 5});
      exp_q.push_back('{1'b0, CSR_MTVAL, 32'h0, 6});
      exp_q.push_back('{1'b1, 12'h0, target, 8});
    end
    bus.irq_ext = 1; bus.irq_pc = 32'h2003;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 20 && bus.csr_own; i++) begin own++; @(negedge clk); end
    tests++;
    if (own !== exp_own) begin fails++; $display("FAIL irq_own_cycles got %0d required %0d", own, exp_own); end
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL irq_missing_events got %0d pending required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (!en && {m_status, m_epc} !== {status, 32'h77}) begin
      fails++;
      $display("FAIL irq_masked_untouched got status=%h epc=%h required %h 77", m_status, m_epc, status);
    end
  endtask

  task automatic test_mret;
    int own = 0;
    @(negedge clk);
    m_status = 32'h1880; m_epc = 32'h3002;
    acc = cyc;
    exp_q.push_back('{1'b0, CSR_MSTATUS, 32'h1888, 2});
    exp_q.push_back('{1'b1, 12'h0, 32'h3000, 4});
    bus.mret_valid = 1; bus.irq_ext = 1;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 20 && bus.csr_own; i++) begin own++; @(negedge clk); end
    tests++;
    if (own !== 4) begin fails++; $display("FAIL mret_own_cycles got %0d required 4", own); end
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL mret_missing_events got %0d pending required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if (m_status !== 32'h1888) begin fails++; $display("FAIL mret_status got %h required 1888", m_status); end
  endtask

  task automatic test_reset_mid_sequence;
    @(negedge clk);
    m_status = 32'h8; m_tvec = 32'h100; m_epc = 0; m_cause = 0; m_tval = 32'h55;
    acc = cyc;
    exp_q.push_back('{1'b0, CSR_MSTATUS, 32'h1880, 2});
    exp_q.push_back('{1'b0, CSR_MEPC, 32'h1004, 3});
    exp_q.push_back('{1'b0, CSR_MCAUSE, 32'h2, 4});
    bus.exc_valid = 1; bus.exc_cause = 2; bus.exc_pc = 32'h1006; bus.exc_tval = 32'hDEAD;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    tests++;
    if ({bus.csr_own, bus.csr_we, bus.csr_re, bus.redirect_valid, bus.csr_addr, bus.csr_wdata, bus.redirect_pc} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs got own=%0b we=%0b re=%0b rv=%0b addr=%h wdata=%h rpc=%h required all 0",
               bus.csr_own, bus.csr_we, bus.csr_re, bus.redirect_valid, bus.csr_addr, bus.csr_wdata, bus.redirect_pc);
    end
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL rst_mid_events got %0d pending required 0", exp_q.size()); exp_q.delete(); end
    tests++;
    if ({m_epc, m_tval} !== {32'h1004, 32'h55}) begin
      fails++;
      $display("FAIL rst_mid_partial got epc=%h tval=%h required 1004 55", m_epc, m_tval);
    end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.csr_own !== 1'b0) begin fails++; $display("FAIL rst_mid_idle got own=%0b required 0", bus.csr_own); end
  endtask

  initial begin
    logic [31:0] vec_target;
`ifdef TRAP_VECTORED_EN
    vec_target = 32'h12C;
`else
    vec_target = 32'h100;
`endif
    test_reset();
    test_exception(32'h100, 1'b0);
    test_exception(32'h101, 1'b1);
    test_irq(32'h8, 32'h800, 32'h100, 32'h100, 8);
    test_irq(32'h0, 32'h800, 32'h100, 32'h100, 2);
    test_irq(32'h8, 32'h0, 32'h100, 32'h100, 2);
    test_irq(32'h8, 32'h800, 32'h101, vec_target, 8);
    test_irq(32'h8, 32'h800, 32'h103, 32'h100, 8);
    test_mret();
    test_reset_mid_sequence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
